hamming_secded_dec: RTL and testbench

HAMMING_SECDED_DEC -- requirements
Module: hamming_secded_dec

---
 rtl/secded_pkg.sv | 64 ++++++
 rtl/secded_syndrome.sv | 40 ++++
 rtl/hamming_secded_dec.sv | 196 +++++++++++++++++++
 tb/tb_hamming_secded_dec.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED Hamming decoder: the status encoding,
// the codeword geometry derived from the message width, and helpers.
package secded_pkg;

  // Classification of a received word
  typedef enum logic [1:0] {
    STAT_CLEAN = 2'b00,
    STAT_CORR  = 2'b01,
    STAT_DBL   = 2'b10
  } stat_e;

  // Number of Hamming parity bits: smallest p with 2^p >= data_w + p + 1
  function automatic int calc_p(input int data_w);
    int p;
    int one;
    p   = 0;
    one = 1;
    for (int i = 1; i < 8; i++) begin
      if ((p == 0) && ((one << i) >= (data_w + i + 1))) begin
        p = i;
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Full codeword width: data + Hamming parity + overall parity p0
  function automatic int calc_code_w(input int data_w);
    return data_w + calc_p(data_w) + 1;
  endfunction

  // Parity of the ones count; narrower words are zero-extended by the caller
  function automatic logic parity64(input logic [63:0] v);
    return ^v;
  endfunction

  // Power-of-two positions hold Hamming parity; the rest carry data
  function automatic logic is_pow2(input int v);
    return ((v & (v - 1)) == 0);
  endfunction

  // Codeword position carrying data bit k (k = 0 is d1)
  function automatic int data_pos(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos < 128; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == k) begin
          res = pos;
        end else begin
          res = res;
        end
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword.
// The syndrome is the XOR of the indices of every set bit above bit 0, so a
// single flipped bit at position i yields exactly i.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int CODE_W = 16,
  localparam int SYN_W = $clog2(CODE_W)
) (
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn,
  output logic              q
);

  logic [63:0] code_ext_s;

  // Widen the codeword so the shared parity helper can be used at any width
  always_comb begin
    code_ext_s = 64'd0;
    code_ext_s[CODE_W-1:0] = code;
  end

  // Accumulate the XOR of indices of set bits (bit 0 is excluded)
  always_comb begin
    syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code[i]) begin
        syn = syn ^ SYN_W'(i);
      end else begin
        syn = syn;
      end
    end
  end

  // Overall parity across every codeword bit, p0 included
  always_comb begin
    q = parity64(code_ext_s);
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage SECDED Hamming decoder with valid/ready handshakes.
// Stage 1 captures the codeword with its syndrome and overall parity;
// stage 2 holds the corrected message and its status. Saturating counters
// track delivered corrected and uncorrectable words.
module hamming_secded_dec
  import secded_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CODE_W = calc_code_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_dbl
);

  localparam logic [P:0]       CODE_LIM = (P + 1)'(CODE_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Pipeline state
  logic              rst_done_r;
  logic              s1_full_r;
  logic [CODE_W-1:0] s1_code_r;
  logic [P-1:0]      s1_syn_r;
  logic              s1_q_r;
  logic              s2_full_r;
  logic [DATA_W-1:0] s2_data_r;
  stat_e             s2_stat_r;
  logic [CNT_W-1:0]  cnt_corr_r;
  logic [CNT_W-1:0]  cnt_dbl_r;

  // Combinational helpers
  logic [P-1:0]      syn_s;
  logic              q_s;
  logic              in_fire_s;
  logic              s2_adv_s;
  logic              out_fire_s;
  logic              syn_in_range_s;
  logic              flip_s;
  stat_e             stat_s;
  logic [CODE_W-1:0] flip_mask_s;
  logic [CODE_W-1:0] corr_code_s;
  logic [DATA_W-1:0] data_s;

  secded_syndrome #(
    .CODE_W(CODE_W)
  ) u_syndrome (
    .code(in_code),
    .syn (syn_s),
    .q   (q_s)
  );

  // Handshake decode; in_ready depends only on registered state and out_ready
  always_comb begin
    out_fire_s = s2_full_r & out_ready;
    s2_adv_s   = s1_full_r & (~s2_full_r | out_ready);
    in_ready   = rst_done_r & (~s1_full_r | s2_adv_s);
    in_fire_s  = in_valid & in_ready;
  end

  // Classify the stage-1 word from its syndrome and overall parity
  always_comb begin
    stat_s         = STAT_CLEAN;
    flip_s         = 1'b0;
    syn_in_range_s = ({1'b0, s1_syn_r} < CODE_LIM);
    if (!s1_q_r) begin
      if (s1_syn_r != '0) begin
        stat_s = STAT_DBL;
      end else begin
        stat_s = STAT_CLEAN;
      end
    end else begin
      if (syn_in_range_s) begin
        stat_s = STAT_CORR;
        flip_s = 1'b1;
      end else begin
        stat_s = STAT_DBL;
      end
    end
  end

  // Invert the bit named by the syndrome; position 0 is p0 and leaves data intact
  always_comb begin
    flip_mask_s = '0;
    if (flip_s) begin
      flip_mask_s[s1_syn_r] = 1'b1;
    end else begin
      flip_mask_s = '0;
    end
    corr_code_s = s1_code_r ^ flip_mask_s;
  end

  // Gather the data bits from the non-power-of-two positions in ascending order
  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int POS = data_pos(k);
    assign data_s[k] = corr_code_s[POS];
  end

  // Becomes 1 on the first edge that samples reset released
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // Stage 1: capture codeword, syndrome and overall parity
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_full_r <= 1'b0;
      s1_code_r <= '0;
      s1_syn_r  <= '0;
      s1_q_r    <= 1'b0;
    end else if (in_fire_s) begin
      s1_full_r <= 1'b1;
      s1_code_r <= in_code;
      s1_syn_r  <= syn_s;
      s1_q_r    <= q_s;
    end else if (s2_adv_s) begin
      s1_full_r <= 1'b0;
    end else begin
      s1_full_r <= s1_full_r;
    end
  end

  // Stage 2: corrected data and status, held while downstream stalls
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_full_r <= 1'b0;
      s2_data_r <= '0;
      s2_stat_r <= STAT_CLEAN;
    end else if (s2_adv_s) begin
      s2_full_r <= 1'b1;
      s2_data_r <= data_s;
      s2_stat_r <= stat_s;
    end else if (out_ready) begin
      s2_full_r <= 1'b0;
    end else begin
      s2_full_r <= s2_full_r;
    end
  end

  // Saturating event counters; a clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_corr_r <= '0;
      cnt_dbl_r  <= '0;
    end else if (cnt_clr) begin
      cnt_corr_r <= '0;
      cnt_dbl_r  <= '0;
    end else if (out_fire_s) begin
      case (s2_stat_r)
        STAT_CORR: begin
          if (cnt_corr_r != CNT_MAX) begin
            cnt_corr_r <= cnt_corr_r + CNT_ONE;
          end else begin
            cnt_corr_r <= cnt_corr_r;
          end
        end
        STAT_DBL: begin
          if (cnt_dbl_r != CNT_MAX) begin
            cnt_dbl_r <= cnt_dbl_r + CNT_ONE;
          end else begin
            cnt_dbl_r <= cnt_dbl_r;
          end
        end
        default: begin
          cnt_corr_r <= cnt_corr_r;
          cnt_dbl_r  <= cnt_dbl_r;
        end
      endcase
    end else begin
      cnt_corr_r <= cnt_corr_r;
      cnt_dbl_r  <= cnt_dbl_r;
    end
  end

  assign out_valid  = s2_full_r;
  assign out_data   = s2_data_r;
  assign out_status = s2_stat_r;
  assign cnt_corr   = cnt_corr_r;
  assign cnt_dbl    = cnt_dbl_r;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Self-checking bench for hamming_secded_dec: directed vectors and a
// randomised back-pressured stream on an 11-bit instance, random error
// injection and counter saturation/clear on a 26-bit instance with 2-bit
// counters. Expectations come from a behavioural encoder/decoder model.
module tb_hamming_secded_dec;

  logic clk;
  logic reset;

  // Instance A: DATA_W=11, CODE_W=16, CNT_W=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
  logic [15:0] a_in_code;
  logic [10:0] a_out_data;
  logic [1:0]  a_out_status;
  logic [15:0] a_cnt_corr, a_cnt_dbl;

  // Instance B: DATA_W=26, CODE_W=32, CNT_W=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
  logic [31:0] b_in_code;
  logic [25:0] b_out_data;
  logic [1:0]  b_out_status;
  logic [1:0]  b_cnt_corr, b_cnt_dbl;

  int n_checks = 0;
  int n_pass   = 0;

  hamming_secded_dec #(.DATA_W(11), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_status(a_out_status),
    .cnt_clr(a_cnt_clr), .cnt_corr(a_cnt_corr), .cnt_dbl(a_cnt_dbl)
  );

  hamming_secded_dec #(.DATA_W(26), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_status(b_out_status),
    .cnt_clr(b_cnt_clr), .cnt_corr(b_cnt_corr), .cnt_dbl(b_cnt_dbl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: place data at non-power-of-two slots, then choose
  // Hamming bits so the index-XOR syndrome is zero and p0 so parity is even.
  function automatic logic [63:0] encode(input logic [63:0] data, input int dw, input int cw);
    logic [63:0] c;
    int k, s;
    c = 64'd0; k = 0; s = 0;
    for (int i = 1; i < cw; i++) begin
      if ((i & (i - 1)) != 0 && k < dw) begin
        c[i] = data[k];
        k++;
      end
    end
    for (int i = 1; i < cw; i++) if (c[i]) s = s ^ i;
    for (int b = 0; b < 7; b++) if (s[b]) c[1 << b] = 1'b1;
    c[0] = ^c;
    return c;
  endfunction

  // Reference decoder straight from the classification rules
  function automatic logic [63:0] ref_decode(input logic [63:0] code, input int dw, input int cw,
                                             output logic [1:0] st);
    logic [63:0] c, d;
    int s, q, k;
    c = code; d = 64'd0; s = 0; q = 0; k = 0;
    for (int i = 0; i < cw; i++) begin
      if (c[i]) begin
        q = q ^ 1;
        if (i > 0) s = s ^ i;
      end
    end
    if (q == 0 && s == 0) st = 2'b00;
    else if (q == 1 && s < cw) begin
      st = 2'b01;
      c[s] = ~c[s];
    end else st = 2'b10;
    for (int i = 1; i < cw; i++) begin
      if ((i & (i - 1)) != 0 && k < dw) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

  // Random codeword with 0, 1 or 2 distinct flipped bits
  function automatic logic [63:0] rand_word(input int dw, input int cw, input int nflip);
    logic [63:0] c;
    int a, b;
    c = encode({$urandom, $urandom}, dw, cw);
    a = $urandom_range(0, cw - 1);
    b = (a + $urandom_range(1, cw - 1)) % cw;
    if (nflip >= 1) c[a] = ~c[a];
    if (nflip >= 2) c[b] = ~c[b];
    return c;
  endfunction

  // One word through instance A with out_ready held high, latency checked
  task automatic a_single(input string tag, input logic [15:0] code,
                          input logic [10:0] exp_d, input logic [1:0] exp_s);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_code  = code;
    #1 check({tag, "_in_ready"}, a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    check({tag, "_lat1_valid"}, a_out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_data"}, a_out_data, exp_d);
    check({tag, "_status"}, a_out_status, exp_s);
    @(negedge clk);
  endtask

  int b_exp_corr = 0;
  int b_exp_dbl  = 0;

  // One word through instance B; optional clear coincident with delivery
  task automatic b_single(input logic [31:0] code, input bit clr_now);
    logic [1:0]  st;
    logic [63:0] d;
    d = ref_decode({32'd0, code}, 26, 32, st);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_code  = code;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_valid", b_out_valid, 1);
    check("b_data", b_out_data, d);
    check("b_status", b_out_status, st);
    b_cnt_clr = clr_now;
    @(negedge clk);
    b_cnt_clr = 1'b0;
    if (clr_now) begin
      b_exp_corr = 0;
      b_exp_dbl  = 0;
    end else if (st == 2'b01) begin
      b_exp_corr = (b_exp_corr < 3) ? b_exp_corr + 1 : 3;
    end else if (st == 2'b10) begin
      b_exp_dbl = (b_exp_dbl < 3) ? b_exp_dbl + 1 : 3;
    end
    check("b_cnt_corr", b_cnt_corr, b_exp_corr);
    check("b_cnt_dbl", b_cnt_dbl, b_exp_dbl);
  endtask

  initial begin
    logic [12:0] exp_q[$];
    logic [12:0] e;
    logic [1:0]  st;
    logic [63:0] d;
    logic [15:0] cur;
    int sent, got, seen;

    reset = 1'b0;
    a_in_valid = 1'b0; a_in_code = 16'd0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
    b_in_valid = 1'b0; b_in_code = 32'd0; b_out_ready = 1'b1; b_cnt_clr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_status", a_out_status, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_cnt_corr", a_cnt_corr, 0);
    check("rst_cnt_dbl", a_cnt_dbl, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1);

    // Directed vectors
    a_single("clean", 16'hFFFF, 11'h7FF, 2'b00);
    check("clean_cnt_corr", a_cnt_corr, 0);
    a_single("bit5", 16'hFFDF, 11'h7FF, 2'b01);
    check("bit5_cnt_corr", a_cnt_corr, 1);
    a_single("p0", 16'hFFFE, 11'h7FF, 2'b01);
    check("p0_cnt_corr", a_cnt_corr, 2);
    a_single("dbl", 16'hFDDF, 11'h7ED, 2'b10);
    check("dbl_cnt_dbl", a_cnt_dbl, 1);

    // Back-to-back random stream with random downstream back-pressure
    sent = 0; got = 0;
    cur = rand_word(11, 16, $urandom_range(0, 2));
    for (int cyc = 0; cyc < 400 && got < 15; cyc++) begin
      @(negedge clk);
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_valid  = (sent < 15);
      a_in_code   = cur;
      #1;
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", a_out_data, e[10:0]);
          check("stream_status", a_out_status, e[12:11]);
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        d = ref_decode({48'd0, cur}, 11, 16, st);
        exp_q.push_back({st, d[10:0]});
        sent++;
        cur = rand_word(11, 16, $urandom_range(0, 2));
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    check("stream_delivered", got, 15);

    // Fill the pipeline under back-pressure, then reset mid-stream
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_code  = rand_word(11, 16, 1);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_cnt_corr", a_cnt_corr, 0);
    check("midrst_cnt_dbl", a_cnt_dbl, 0);
    reset = 1'b1;
    a_out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    check("midrst_no_ghost_words", seen, 0);

    // Wide instance: random single/double errors, saturation, clear priority
    for (int i = 0; i < 20; i++) begin
      b_single(32'(rand_word(26, 32, $urandom_range(1, 2))), 1'b0);
    end
    b_single(32'(rand_word(26, 32, 1)), 1'b1);
    b_single(32'(rand_word(26, 32, 1)), 1'b0);
    b_single(32'(rand_word(26, 32, 2)), 1'b0);
    b_single(32'(rand_word(26, 32, 0)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
